// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared definitions for the ID/EX ALU stage: ALU function codes,
//            opcode / funct / regimm field values, the registered stage
//            record and its bubble value, plus immediate-extension helpers.
//  Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU function codes driven onto iALUFun
    localparam logic [5:0] c_FUN_ADD = 6'b000000;
    localparam logic [5:0] c_FUN_SUB = 6'b000001;
    localparam logic [5:0] c_FUN_AND = 6'b011000;
    localparam logic [5:0] c_FUN_OR  = 6'b011110;
    localparam logic [5:0] c_FUN_XOR = 6'b010110;
    localparam logic [5:0] c_FUN_NOR = 6'b010001;
    localparam logic [5:0] c_FUN_SLL = 6'b100000;
    localparam logic [5:0] c_FUN_SRL = 6'b100001;
    localparam logic [5:0] c_FUN_SRA = 6'b100011;
    localparam logic [5:0] c_FUN_EQ  = 6'b110011;
    localparam logic [5:0] c_FUN_NEQ = 6'b110001;
    localparam logic [5:0] c_FUN_LT  = 6'b110101;
    localparam logic [5:0] c_FUN_LEZ = 6'b111101;
    localparam logic [5:0] c_FUN_GEZ = 6'b111001;
    localparam logic [5:0] c_FUN_GTZ = 6'b111111;
    localparam logic [5:0] c_FUN_LUI = 6'b011011;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_REGIMM = 6'h01;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_BNE    = 6'h05;
    localparam logic [5:0] c_OP_BLEZ   = 6'h06;
    localparam logic [5:0] c_OP_BGTZ   = 6'h07;
    localparam logic [5:0] c_OP_ADDI   = 6'h08;
    localparam logic [5:0] c_OP_ADDIU  = 6'h09;
    localparam logic [5:0] c_OP_SLTI   = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU  = 6'h0B;
    localparam logic [5:0] c_OP_ANDI   = 6'h0C;
    localparam logic [5:0] c_OP_ORI    = 6'h0D;
    localparam logic [5:0] c_OP_XORI   = 6'h0E;
    localparam logic [5:0] c_OP_LUI    = 6'h0F;
    localparam logic [5:0] c_OP_LW     = 6'h23;
    localparam logic [5:0] c_OP_SW     = 6'h2B;

    // R-type funct values
    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    // REGIMM rt selector values
    localparam logic [4:0] c_RI_BLTZ = 5'd0;
    localparam logic [4:0] c_RI_BGEZ = 5'd1;

    // Everything the stage registers for EX (oOvfChk is kept separately so it
    // can vanish entirely when the overflow trap is not built).
    typedef struct packed {
        logic        valid;
        logic        regWe;
        logic [4:0]  rd;
        logic        memRd;
        logic        memWr;
        logic        illegal;
        logic [5:0]  aluFun;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] stData;
    } stage_t;

    // Bubble: all zero, which also makes the function code ADD.
    localparam stage_t c_BUBBLE = '0;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_mux
//  Purpose : Three-way operand forward select for one source register.
//            EX/MEM beats MEM/WB; register 0 is never forwarded.
//  Ports   : i_addr      source register index
//            i_rfData    register-file read value
//            i_exMem*    EX/MEM write enable / register / data
//            i_memWb*    MEM/WB write enable / register / data
//            o_data      selected operand value
//  Revision: 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_addr,
    input  logic [DW-1:0] i_rfData,
    input  logic          i_exMemWe,
    input  logic [RW-1:0] i_exMemRd,
    input  logic [DW-1:0] i_exMemData,
    input  logic          i_memWbWe,
    input  logic [RW-1:0] i_memWbRd,
    input  logic [DW-1:0] i_memWbData,
    output logic [DW-1:0] o_data
);

    always_comb begin
        o_data = i_rfData;
        if (i_addr != '0) begin
            if (i_exMemWe && (i_exMemRd == i_addr)) begin
                o_data = i_exMemData;
            end else if (i_memWbWe && (i_memWbRd == i_addr)) begin
                o_data = i_memWbData;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_alu_stage.sv
`default_nettype none
// ============================================================================
//  Module  : id_ex_alu_stage
//  Purpose : ID/EX pipeline register feeding the ALU. Decodes the instruction
//            into function code, sign mode and operands, resolves EX/MEM and
//            MEM/WB forwarding, detects load-use hazards and registers the
//            result for EX (1-cycle latency).
//  Ports   : iClk, iRst (sync, active-high)
//            iValid, iInstr, iRsData, iRtData        - from IF/ID and regfile
//            iExMemWe/Rd/Data, iMemWbWe/Rd/Data      - forward sources
//            iStall (freeze), iFlush (squash incoming)
//            oA, oB, oALUFun, oSign                  - ALU inputs
//            oValid, oRegWe, oRd, oMemRd, oMemWr,
//            oStData, oIllegal, oOvfChk              - registered control
//            oLoadUse                                - combinational hold req
//  Config  : ID_EX_OVF_TRAP_EN - when defined, oOvfChk is registered high for
//            add, sub and addi; otherwise oOvfChk is constant 0.
//  Revision: 1.0 - initial release
// ============================================================================
module id_ex_alu_stage
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iValid,
    input  logic [31:0]   iInstr,
    input  logic [DW-1:0] iRsData,
    input  logic [DW-1:0] iRtData,
    input  logic          iExMemWe,
    input  logic [RW-1:0] iExMemRd,
    input  logic [DW-1:0] iExMemData,
    input  logic          iMemWbWe,
    input  logic [RW-1:0] iMemWbRd,
    input  logic [DW-1:0] iMemWbData,
    input  logic          iStall,
    input  logic          iFlush,
    output logic [DW-1:0] oA,
    output logic [DW-1:0] oB,
    output logic [5:0]    oALUFun,
    output logic          oSign,
    output logic          oValid,
    output logic          oRegWe,
    output logic [RW-1:0] oRd,
    output logic          oMemRd,
    output logic          oMemWr,
    output logic [DW-1:0] oStData,
    output logic          oIllegal,
    output logic          oOvfChk,
    output logic          oLoadUse
);

    // Instruction fields
    logic [5:0]    w_opcode;
    logic [RW-1:0] w_rs;
    logic [RW-1:0] w_rt;
    logic [RW-1:0] w_rd;
    logic [4:0]    w_shamt;
    logic [5:0]    w_funct;
    logic [15:0]   w_imm;

    assign w_opcode = iInstr[31:26];
    assign w_rs     = iInstr[25:21];
    assign w_rt     = iInstr[20:16];
    assign w_rd     = iInstr[15:11];
    assign w_shamt  = iInstr[10:6];
    assign w_funct  = iInstr[5:0];
    assign w_imm    = iInstr[15:0];

    // Forwarded source operands
    logic [DW-1:0] w_fwdRs;
    logic [DW-1:0] w_fwdRt;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwdRs (
        .i_addr      (w_rs),
        .i_rfData    (iRsData),
        .i_exMemWe   (iExMemWe),
        .i_exMemRd   (iExMemRd),
        .i_exMemData (iExMemData),
        .i_memWbWe   (iMemWbWe),
        .i_memWbRd   (iMemWbRd),
        .i_memWbData (iMemWbData),
        .o_data      (w_fwdRs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwdRt (
        .i_addr      (w_rt),
        .i_rfData    (iRtData),
        .i_exMemWe   (iExMemWe),
        .i_exMemRd   (iExMemRd),
        .i_exMemData (iExMemData),
        .i_memWbWe   (iMemWbWe),
        .i_memWbRd   (iMemWbRd),
        .i_memWbData (iMemWbData),
        .o_data      (w_fwdRt)
    );

    // Decode
    stage_t w_dec;
    logic   w_readsRt;
    logic   w_illegal;

    always_comb begin
        w_dec        = c_BUBBLE;
        w_readsRt    = 1'b0;
        w_illegal    = 1'b0;
        w_dec.valid  = 1'b1;
        w_dec.a      = w_fwdRs;
        w_dec.b      = w_fwdRt;
        w_dec.stData = w_fwdRt;

        case (w_opcode)
            c_OP_RTYPE: begin
                w_readsRt   = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.regWe = (w_rd != '0);
                case (w_funct)
                    c_FN_ADD:  begin w_dec.aluFun = c_FUN_ADD; w_dec.sign = 1'b1; end
                    c_FN_ADDU: begin w_dec.aluFun = c_FUN_ADD; w_dec.sign = 1'b0; end
                    c_FN_SUB:  begin w_dec.aluFun = c_FUN_SUB; w_dec.sign = 1'b1; end
                    c_FN_SUBU: begin w_dec.aluFun = c_FUN_SUB; w_dec.sign = 1'b0; end
                    c_FN_AND:  w_dec.aluFun = c_FUN_AND;
                    c_FN_OR:   w_dec.aluFun = c_FUN_OR;
                    c_FN_XOR:  w_dec.aluFun = c_FUN_XOR;
                    c_FN_NOR:  w_dec.aluFun = c_FUN_NOR;
                    c_FN_SLT:  begin w_dec.aluFun = c_FUN_LT; w_dec.sign = 1'b1; end
                    c_FN_SLTU: begin w_dec.aluFun = c_FUN_LT; w_dec.sign = 1'b0; end
                    // Shifts take the shift amount on A and the value on B.
                    c_FN_SLL:  begin w_dec.aluFun = c_FUN_SLL; w_dec.a = {27'd0, w_shamt}; end
                    c_FN_SRL:  begin w_dec.aluFun = c_FUN_SRL; w_dec.a = {27'd0, w_shamt}; end
                    c_FN_SRA:  begin w_dec.aluFun = c_FUN_SRA; w_dec.a = {27'd0, w_shamt}; end
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU, c_OP_LW: begin
                w_dec.rd    = w_rt;
                w_dec.regWe = (w_rt != '0);
                w_dec.b     = sext16(w_imm);
                w_dec.sign  = (w_opcode == c_OP_ADDI) || (w_opcode == c_OP_SLTI);
                w_dec.aluFun = ((w_opcode == c_OP_SLTI) || (w_opcode == c_OP_SLTIU))
                             ? c_FUN_LT : c_FUN_ADD;
                w_dec.memRd = (w_opcode == c_OP_LW);
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
                w_dec.rd    = w_rt;
                w_dec.regWe = (w_rt != '0);
                w_dec.b     = zext16(w_imm);
                case (w_opcode)
                    c_OP_ANDI: w_dec.aluFun = c_FUN_AND;
                    c_OP_ORI:  w_dec.aluFun = c_FUN_OR;
                    c_OP_XORI: w_dec.aluFun = c_FUN_XOR;
                    default:   w_dec.aluFun = c_FUN_LUI;
                endcase
            end
            c_OP_SW: begin
                // Store: address from rs+sext(imm); rt is read as store data.
                w_readsRt    = 1'b1;
                w_dec.rd     = w_rt;
                w_dec.b      = sext16(w_imm);
                w_dec.aluFun = c_FUN_ADD;
                w_dec.memWr  = 1'b1;
            end
            c_OP_BEQ:  begin w_readsRt = 1'b1; w_dec.aluFun = c_FUN_EQ;  end
            c_OP_BNE:  begin w_readsRt = 1'b1; w_dec.aluFun = c_FUN_NEQ; end
            c_OP_BLEZ: w_dec.aluFun = c_FUN_LEZ;
            c_OP_BGTZ: w_dec.aluFun = c_FUN_GTZ;
            c_OP_REGIMM: begin
                if (w_rt == c_RI_BLTZ) begin
                    w_dec.aluFun = c_FUN_LT;
                    w_dec.b      = '0;
                    w_dec.sign   = 1'b1;
                end else if (w_rt == c_RI_BGEZ) begin
                    w_dec.aluFun = c_FUN_GEZ;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase

        // Unknown encodings travel as a visible bubble so EX can trap on them.
        if (w_illegal) begin
            w_dec         = c_BUBBLE;
            w_dec.valid   = 1'b1;
            w_dec.illegal = 1'b1;
        end
    end

    // Stage register
    stage_t r_st;
    logic   w_hold;
    logic   w_bubble;

    // A load in EX whose destination is a source of the incoming instruction.
    assign oLoadUse = r_st.valid & r_st.memRd & (r_st.rd != '0) & iValid &
                      ((r_st.rd == w_rs) | ((r_st.rd == w_rt) & w_readsRt));

    // Flush outranks stall; stall outranks the load-use bubble.
    assign w_hold   = iStall & ~iFlush;
    assign w_bubble = iFlush | oLoadUse | ~iValid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_st <= c_BUBBLE;
        end else if (!w_hold) begin
            r_st <= w_bubble ? c_BUBBLE : w_dec;
        end
    end

`ifdef ID_EX_OVF_TRAP_EN
    logic w_ovfNext;
    logic r_ovfChk;

    always_comb begin
        w_ovfNext = 1'b0;
        if (w_opcode == c_OP_RTYPE) begin
            w_ovfNext = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB);
        end else if (w_opcode == c_OP_ADDI) begin
            w_ovfNext = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ovfChk <= 1'b0;
        end else if (!w_hold) begin
            r_ovfChk <= w_bubble ? 1'b0 : w_ovfNext;
        end
    end

    assign oOvfChk = r_ovfChk;
`else
    assign oOvfChk = 1'b0;
`endif

    assign oA       = r_st.a;
    assign oB       = r_st.b;
    assign oALUFun  = r_st.aluFun;
    assign oSign    = r_st.sign;
    assign oValid   = r_st.valid;
    assign oRegWe   = r_st.regWe;
    assign oRd      = r_st.rd;
    assign oMemRd   = r_st.memRd;
    assign oMemWr   = r_st.memWr;
    assign oStData  = r_st.stData;
    assign oIllegal = r_st.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_alu_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_id_ex_alu_stage
//  Purpose : Directed self-checking bench for id_ex_alu_stage.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_alu_stage;

`ifdef ID_EX_OVF_TRAP_EN
    localparam logic [31:0] c_OVF_SUB = 32'd1;
`else
    localparam logic [31:0] c_OVF_SUB = 32'd0;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic [31:0] iInstr;
    logic [31:0] iRsData;
    logic [31:0] iRtData;
    logic        iExMemWe;
    logic [4:0]  iExMemRd;
    logic [31:0] iExMemData;
    logic        iMemWbWe;
    logic [4:0]  iMemWbRd;
    logic [31:0] iMemWbData;
    logic        iStall;
    logic        iFlush;
    logic [31:0] oA;
    logic [31:0] oB;
    logic [5:0]  oALUFun;
    logic        oSign;
    logic        oValid;
    logic        oRegWe;
    logic [4:0]  oRd;
    logic        oMemRd;
    logic        oMemWr;
    logic [31:0] oStData;
    logic        oIllegal;
    logic        oOvfChk;
    logic        oLoadUse;

    int errCnt = 0;
    int chkCnt = 0;

    id_ex_alu_stage #(.DW(32), .RW(5)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iInstr(iInstr),
        .iRsData(iRsData), .iRtData(iRtData),
        .iExMemWe(iExMemWe), .iExMemRd(iExMemRd), .iExMemData(iExMemData),
        .iMemWbWe(iMemWbWe), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
        .iStall(iStall), .iFlush(iFlush),
        .oA(oA), .oB(oB), .oALUFun(oALUFun), .oSign(oSign), .oValid(oValid),
        .oRegWe(oRegWe), .oRd(oRd), .oMemRd(oMemRd), .oMemWr(oMemWr),
        .oStData(oStData), .oIllegal(oIllegal), .oOvfChk(oOvfChk),
        .oLoadUse(oLoadUse)
    );

    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        iValid  = 1'b1;
        iInstr  = instr;
        iRsData = rs;
        iRtData = rt;
    endtask

    task automatic clearFwd();
        iExMemWe = 1'b0; iExMemRd = 5'd0; iExMemData = 32'd0;
        iMemWbWe = 1'b0; iMemWbRd = 5'd0; iMemWbData = 32'd0;
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iInstr = 32'd0; iRsData = 32'd0; iRtData = 32'd0;
        iStall = 1'b0; iFlush = 1'b0;
        clearFwd();
        tick();
        tick();
        // Reset state
        checkEq("rst_valid",  32'(oValid),   32'd0);
        checkEq("rst_a",      oA,            32'd0);
        checkEq("rst_fun",    32'(oALUFun),  32'd0);
        checkEq("rst_regwe",  32'(oRegWe),   32'd0);
        checkEq("rst_ovf",    32'(oOvfChk),  32'd0);
        iRst = 1'b0;

        // addi $3,$0,-5
        drive(encI(6'h08, 5'd0, 5'd3, 16'hFFFB), 32'd0, 32'h99);
        tick();
        checkEq("addi_a",     oA,            32'd0);
        checkEq("addi_b",     oB,            32'hFFFFFFFB);
        checkEq("addi_fun",   32'(oALUFun),  32'h00);
        checkEq("addi_sign",  32'(oSign),    32'd1);
        checkEq("addi_rd",    32'(oRd),      32'd3);
        checkEq("addi_regwe", 32'(oRegWe),   32'd1);
        checkEq("addi_valid", 32'(oValid),   32'd1);
        checkEq("addi_ovf",   32'(oOvfChk),  c_OVF_SUB);

        // add $4,$1,$2 : EX/MEM and MEM/WB both target $1, EX/MEM wins
        iExMemWe = 1'b1; iExMemRd = 5'd1; iExMemData = 32'h11;
        iMemWbWe = 1'b1; iMemWbRd = 5'd1; iMemWbData = 32'h22;
        drive(encR(5'd1, 5'd2, 5'd4, 5'd0, 6'h20), 32'hAAAA, 32'h5);
        tick();
        checkEq("fwd_exmem_a", oA,           32'h11);
        checkEq("fwd_exmem_b", oB,           32'h5);
        checkEq("add_rd",      32'(oRd),     32'd4);

        // MEM/WB alone feeds rt; EX/MEM points elsewhere
        iExMemRd = 5'd7; iMemWbRd = 5'd2; iMemWbData = 32'h33;
        drive(encR(5'd1, 5'd2, 5'd4, 5'd0, 6'h20), 32'hAAAA, 32'h5);
        tick();
        checkEq("fwd_memwb_a", oA,           32'hAAAA);
        checkEq("fwd_memwb_b", oB,           32'h33);

        // $0 is never forwarded
        iExMemRd = 5'd0; iExMemData = 32'h77;
        drive(encR(5'd0, 5'd2, 5'd4, 5'd0, 6'h20), 32'd0, 32'h5);
        tick();
        checkEq("fwd_r0_a",    oA,           32'd0);
        clearFwd();

        // lw $5,16($1)
        drive(encI(6'h23, 5'd1, 5'd5, 16'h0010), 32'h100, 32'h0);
        tick();
        checkEq("lw_memrd",   32'(oMemRd),   32'd1);
        checkEq("lw_a",       oA,            32'h100);
        checkEq("lw_b",       oB,            32'h10);
        checkEq("lw_sign",    32'(oSign),    32'd0);
        // addi $5,$2,1 only writes $5, no hazard
        drive(encI(6'h08, 5'd2, 5'd5, 16'h0001), 32'h0, 32'h0);
        #1;
        checkEq("lu_noread",  32'(oLoadUse), 32'd0);
        // sub $6,$5,$2 reads the loaded register
        drive(encR(5'd5, 5'd2, 5'd6, 5'd0, 6'h22), 32'hDEAD, 32'h3);
        #1;
        checkEq("lu_hit",     32'(oLoadUse), 32'd1);
        tick();
        checkEq("lu_bubble",  32'(oValid),   32'd0);
        checkEq("lu_bub_we",  32'(oRegWe),   32'd0);
        checkEq("lu_clear",   32'(oLoadUse), 32'd0);
        iExMemWe = 1'b1; iExMemRd = 5'd5; iExMemData = 32'h500;
        tick();
        checkEq("sub_valid",  32'(oValid),   32'd1);
        checkEq("sub_a",      oA,            32'h500);
        checkEq("sub_b",      oB,            32'h3);
        checkEq("sub_fun",    32'(oALUFun),  32'h01);
        checkEq("sub_sign",   32'(oSign),    32'd1);
        checkEq("sub_ovf",    32'(oOvfChk),  c_OVF_SUB);
        clearFwd();

        // subu $6,$1,$2
        drive(encR(5'd1, 5'd2, 5'd6, 5'd0, 6'h23), 32'h9, 32'h4);
        tick();
        checkEq("subu_sign",  32'(oSign),    32'd0);
        checkEq("subu_ovf",   32'(oOvfChk),  32'd0);

        // or $8,$1,$2 then flush+stall on the same instruction
        drive(encR(5'd1, 5'd2, 5'd8, 5'd0, 6'h25), 32'hF0, 32'h0F);
        tick();
        checkEq("or_fun",     32'(oALUFun),  32'h1E);
        checkEq("or_valid",   32'(oValid),   32'd1);
        iFlush = 1'b1; iStall = 1'b1;
        tick();
        checkEq("flush_valid", 32'(oValid),  32'd0);
        checkEq("flush_a",    oA,            32'd0);
        checkEq("flush_fun",  32'(oALUFun),  32'h00);
        iFlush = 1'b0; iStall = 1'b0;

        // xor $9,$1,$2, then stall for 3 cycles while a nor is presented
        drive(encR(5'd1, 5'd2, 5'd9, 5'd0, 6'h26), 32'hF0, 32'hFF);
        tick();
        iStall = 1'b1;
        drive(encR(5'd3, 5'd4, 5'd10, 5'd0, 6'h27), 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("stall_a",   oA,           32'hF0);
            checkEq("stall_b",   oB,           32'hFF);
            checkEq("stall_fun", 32'(oALUFun), 32'h16);
            checkEq("stall_rd",  32'(oRd),     32'd9);
        end
        iStall = 1'b0;
        iValid = 1'b0;
        tick();
        checkEq("novalid",    32'(oValid),   32'd0);

        // sll $2,$3,7
        drive(encR(5'd0, 5'd3, 5'd2, 5'd7, 6'h00), 32'h0, 32'h1234);
        tick();
        checkEq("sll_a",      oA,            32'd7);
        checkEq("sll_b",      oB,            32'h1234);
        checkEq("sll_fun",    32'(oALUFun),  32'h20);
        checkEq("sll_rd",     32'(oRd),      32'd2);

        // opcode 0x3F
        drive(encI(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h55, 32'h66);
        tick();
        checkEq("ill_flag",   32'(oIllegal), 32'd1);
        checkEq("ill_valid",  32'(oValid),   32'd1);
        checkEq("ill_regwe",  32'(oRegWe),   32'd0);
        checkEq("ill_a",      oA,            32'd0);

        // add $0,$1,$2 : no write-back
        drive(encR(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'h1, 32'h2);
        tick();
        checkEq("rd0_regwe",  32'(oRegWe),   32'd0);
        checkEq("rd0_ill",    32'(oIllegal), 32'd0);

        // ori $12,$0,0x8001 : zero-extended
        drive(encI(6'h0D, 5'd0, 5'd12, 16'h8001), 32'h0, 32'h0);
        tick();
        checkEq("ori_b",      oB,            32'h00008001);
        checkEq("ori_fun",    32'(oALUFun),  32'h1E);

        // sw $7,4($1) with $7 forwarded from MEM/WB
        iMemWbWe = 1'b1; iMemWbRd = 5'd7; iMemWbData = 32'hCAFE;
        drive(encI(6'h2B, 5'd1, 5'd7, 16'h0004), 32'h200, 32'h1);
        tick();
        checkEq("sw_memwr",   32'(oMemWr),   32'd1);
        checkEq("sw_regwe",   32'(oRegWe),   32'd0);
        checkEq("sw_stdata",  oStData,       32'hCAFE);
        checkEq("sw_b",       oB,            32'd4);
        clearFwd();

        // beq $1,$2 ; bltz $1
        drive(encI(6'h04, 5'd1, 5'd2, 16'h0003), 32'h8, 32'h9);
        tick();
        checkEq("beq_fun",    32'(oALUFun),  32'h33);
        checkEq("beq_regwe",  32'(oRegWe),   32'd0);
        checkEq("beq_b",      oB,            32'h9);
        drive(encI(6'h01, 5'd1, 5'd0, 16'h0003), 32'h8, 32'h9);
        tick();
        checkEq("bltz_fun",   32'(oALUFun),  32'h35);
        checkEq("bltz_b",     oB,            32'd0);
        checkEq("bltz_sign",  32'(oSign),    32'd1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
`default_nettype wire
